// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receiver: default slot geometry, FSM state
// encoding and the width rule for the per-slot edge counter.
package i2s_pkg;

    localparam int DEF_SAMPLE_WIDTH = 16;
    localparam int DEF_SLOT_WIDTH   = 32;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

    // The counter must be able to hold SLOT_WIDTH itself, where it saturates.
    function automatic int edge_cnt_width(input int slot_width);
        return $clog2(slot_width + 1);
    endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// Multi-stage input synchronizer with an optional registered rising-edge
// detector; plain instances tie rise_o low so all inputs keep equal depth.
import i2s_pkg::*;

module i2s_rx_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_DET    = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_DET) begin : g_edge
            logic prev_q;
            logic rise_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    prev_q <= 1'b0;
                    rise_q <= 1'b0;
                end else begin
                    prev_q <= q_o;
                    rise_q <= q_o & ~prev_q;
                end
            end

            assign rise_o = rise_q;
        end else begin : g_plain
            assign rise_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/i2s_rx.sv
// I2S stereo receiver: oversamples SCLK/LRCK/SDATA, deserializes slots and
// commits L/R pairs. Define I2S_RX_LEFT_JUSTIFIED_EN for left-justified format.
import i2s_pkg::*;

module i2s_rx #(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = DEF_SLOT_WIDTH,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i2s_sclk,
    input  logic                    i2s_lrck,
    input  logic                    i2s_sdata,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    sample_valid,
    output logic                    frame_error,
    input  logic                    error_clear
);

    localparam int             CNT_W      = edge_cnt_width(SLOT_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SLOT_WIDTH);
    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_WIDTH);
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    localparam logic [CNT_W-1:0] GOOD_CNT   = CNT_W'(SLOT_WIDTH);
`else
    localparam logic [CNT_W-1:0] GOOD_CNT   = CNT_W'(SLOT_WIDTH - 1);
`endif

    logic sclk_rise, lrck_s, sdata_s;
    logic unused_lrck_rise, unused_sdata_rise;

    i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .d_i(i2s_sclk), .q_o(), .rise_o(sclk_rise)
    );
    i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sync_lrck (
        .clk(clk), .reset_n(reset_n), .d_i(i2s_lrck), .q_o(lrck_s), .rise_o(unused_lrck_rise)
    );
    i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sync_sdata (
        .clk(clk), .reset_n(reset_n), .d_i(i2s_sdata), .q_o(sdata_s), .rise_o(unused_sdata_rise)
    );

    i2s_state_e              state_q, state_d;
    logic [CNT_W-1:0]        edge_cnt_q, edge_cnt_d;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
    logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
    logic [SAMPLE_WIDTH-1:0] left_sample_q, left_sample_d;
    logic [SAMPLE_WIDTH-1:0] right_sample_q, right_sample_d;
    logic                    left_ok_q, left_ok_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    lrck_prev_q, lrck_prev_d;
    logic                    lrck_vld_q, lrck_vld_d;
    logic                    trans, slot_good, err_set;

    // The first bit event after reset only records LRCK, so a reset inside a
    // right slot cannot fake a transition.
    assign trans     = sclk_rise & lrck_vld_q & (lrck_s != lrck_prev_q);
    assign slot_good = (edge_cnt_q == GOOD_CNT);

    always_comb begin
        edge_cnt_d  = edge_cnt_q;
        shift_d     = shift_q;
        lrck_prev_d = lrck_prev_q;
        lrck_vld_d  = lrck_vld_q;
        if (sclk_rise) begin
            lrck_prev_d = lrck_s;
            lrck_vld_d  = 1'b1;
            if (trans) begin
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
                shift_d    = {shift_q[SAMPLE_WIDTH-2:0], sdata_s};
                edge_cnt_d = CNT_W'(1);
`else
                edge_cnt_d = '0;
`endif
            end else begin
                if (edge_cnt_q < SAMPLE_CNT) begin
                    shift_d = {shift_q[SAMPLE_WIDTH-2:0], sdata_s};
                end
                if (edge_cnt_q != CNT_MAX) begin
                    edge_cnt_d = edge_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        left_hold_d    = left_hold_q;
        left_ok_d      = left_ok_q;
        left_sample_d  = left_sample_q;
        right_sample_d = right_sample_q;
        valid_d        = 1'b0;
        err_set        = 1'b0;
        case (state_q)
            HUNT: begin
                if (trans) state_d = lrck_s ? RIGHT : LEFT;
            end
            LEFT: begin
                if (trans) begin
                    if (slot_good) begin
                        left_hold_d = shift_q;
                        left_ok_d   = 1'b1;
                    end else begin
                        left_ok_d   = 1'b0;
                        err_set     = 1'b1;
                    end
                    state_d = RIGHT;
                end
            end
            RIGHT: begin
                if (trans) begin
                    if (!slot_good) begin
                        err_set = 1'b1;
                    end else if (left_ok_q) begin
                        left_sample_d  = left_hold_q;
                        right_sample_d = shift_q;
                        valid_d        = 1'b1;
                    end
                    state_d = LEFT;
                end
            end
            default: state_d = HUNT;
        endcase
        err_d = err_set | (err_q & ~error_clear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= HUNT;
            edge_cnt_q     <= '0;
            shift_q        <= '0;
            left_hold_q    <= '0;
            left_ok_q      <= 1'b0;
            left_sample_q  <= '0;
            right_sample_q <= '0;
            valid_q        <= 1'b0;
            err_q          <= 1'b0;
            lrck_prev_q    <= 1'b0;
            lrck_vld_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            shift_q        <= shift_d;
            left_hold_q    <= left_hold_d;
            left_ok_q      <= left_ok_d;
            left_sample_q  <= left_sample_d;
            right_sample_q <= right_sample_d;
            valid_q        <= valid_d;
            err_q          <= err_d;
            lrck_prev_q    <= lrck_prev_d;
            lrck_vld_q     <= lrck_vld_d;
        end
    end

    assign left_sample  = left_sample_q;
    assign right_sample = right_sample_q;
    assign sample_valid = valid_q;
    assign frame_error  = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: frames, slot errors, error clear, mid-slot reset
// and minimum SCLK phase timing with latency measurement.
module tb_i2s_rx;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i2s_sclk = 1'b0;
    logic        i2s_lrck = 1'b1;
    logic        i2s_sdata = 1'b0;
    logic        error_clear = 1'b0;
    logic [15:0] left_sample, right_sample;
    logic        sample_valid, frame_error;

    int total = 0;
    int bad = 0;
    int ph = 6;
    int cyc = 0;
    int vcnt = 0;
    int vld_cyc = 0;
    int trans_cyc = 0;
    int base = 0;
    bit clr_on_trans = 1'b0;
    logic prev_v = 1'b0;
    logic consec = 1'b0;

    i2s_rx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset_n(reset_n), .i2s_sclk(i2s_sclk), .i2s_lrck(i2s_lrck),
        .i2s_sdata(i2s_sdata), .left_sample(left_sample), .right_sample(right_sample),
        .sample_valid(sample_valid), .frame_error(frame_error), .error_clear(error_clear)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_v <= sample_valid;
        if (sample_valid) begin
            vcnt    <= vcnt + 1;
            vld_cyc <= cyc;
        end
        if (sample_valid && prev_v) consec <= 1'b1;
    end

    task automatic idle(input int n);
        i2s_sclk = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_bit(input logic lr, input logic d, input bit is_trans);
        i2s_sclk  = 1'b0;
        i2s_lrck  = lr;
        i2s_sdata = d;
        repeat (ph) begin @(posedge clk); #1; end
        i2s_sclk = 1'b1;
        if (is_trans) trans_cyc = cyc;
        for (int j = 0; j < ph; j++) begin
            @(posedge clk); #1;
            error_clear = clr_on_trans && is_trans && (j == SYNC);
        end
    endtask

    // Slot bit positions first..first+n-1; position 0 is the LRCK transition edge.
    task automatic send_slot(input logic lr, input logic [15:0] data, input int first, input int n);
        int idx;
        logic b;
        for (int i = first; i < first + n; i++) begin
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
            idx = 15 - i;
`else
            idx = 16 - i;
            if (i == 0) idx = -1;
`endif
            b = (idx >= 0 && idx < 16) ? data[idx[3:0]] : 1'b0;
            drive_bit(lr, b, i == 0);
        end
    endtask

    task automatic apply_reset();
        i2s_sclk = 1'b0; i2s_lrck = 1'b1; i2s_sdata = 1'b0; error_clear = 1'b0;
        reset_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset_n = 1'b1;
        @(posedge clk); #1;
        base = vcnt;
        send_slot(1'b1, 16'h0000, 20, 4);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        total++; if (left_sample !== 16'h0000) begin bad++; $display("FAIL reset_left: got %h want 0000", left_sample); end
        total++; if (right_sample !== 16'h0000) begin bad++; $display("FAIL reset_right: got %h want 0000", right_sample); end
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
        total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", frame_error); end
    endtask

    task automatic test_standard();
        apply_reset();
        send_slot(1'b0, 16'hA55A, 0, 32);
        send_slot(1'b1, 16'h1234, 0, 32);
        send_slot(1'b0, 16'hA55A, 0, 1);
        idle(8);
        total++; if (vcnt - base !== 1) begin bad++; $display("FAIL std_cnt1: got %0d want 1", vcnt - base); end
        total++; if (left_sample !== 16'hA55A) begin bad++; $display("FAIL std_left1: got %h want a55a", left_sample); end
        total++; if (right_sample !== 16'h1234) begin bad++; $display("FAIL std_right1: got %h want 1234", right_sample); end
        send_slot(1'b0, 16'hA55A, 1, 31);
        send_slot(1'b1, 16'h1234, 0, 32);
        send_slot(1'b0, 16'h0000, 0, 1);
        idle(8);
        total++; if (vcnt - base !== 2) begin bad++; $display("FAIL std_cnt2: got %0d want 2", vcnt - base); end
        total++; if (left_sample !== 16'hA55A) begin bad++; $display("FAIL std_left2: got %h want a55a", left_sample); end
        total++; if (right_sample !== 16'h1234) begin bad++; $display("FAIL std_right2: got %h want 1234", right_sample); end
        total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL std_err: got %b want 0", frame_error); end
    endtask

    task automatic test_short_slot();
        apply_reset();
        send_slot(1'b0, 16'hA55A, 0, 32);
        send_slot(1'b1, 16'h1234, 0, 32);
        send_slot(1'b0, 16'h1111, 0, 32);
        send_slot(1'b1, 16'h2222, 0, 31);
        send_slot(1'b0, 16'h3333, 0, 32);
        idle(8);
        total++; if (vcnt - base !== 1) begin bad++; $display("FAIL short_cnt1: got %0d want 1", vcnt - base); end
        total++; if (left_sample !== 16'hA55A) begin bad++; $display("FAIL short_hold_left: got %h want a55a", left_sample); end
        total++; if (right_sample !== 16'h1234) begin bad++; $display("FAIL short_hold_right: got %h want 1234", right_sample); end
        total++; if (frame_error !== 1'b1) begin bad++; $display("FAIL short_err: got %b want 1", frame_error); end
        send_slot(1'b1, 16'h4444, 0, 32);
        send_slot(1'b0, 16'h0000, 0, 1);
        idle(8);
        total++; if (vcnt - base !== 2) begin bad++; $display("FAIL short_cnt2: got %0d want 2", vcnt - base); end
        total++; if (left_sample !== 16'h3333) begin bad++; $display("FAIL short_left2: got %h want 3333", left_sample); end
        total++; if (right_sample !== 16'h4444) begin bad++; $display("FAIL short_right2: got %h want 4444", right_sample); end
        total++; if (frame_error !== 1'b1) begin bad++; $display("FAIL short_err_sticky: got %b want 1", frame_error); end
    endtask

    task automatic test_error_clear();
        apply_reset();
        send_slot(1'b0, 16'h1111, 0, 32);
        send_slot(1'b1, 16'h2222, 0, 31);
        clr_on_trans = 1'b1;
        send_slot(1'b0, 16'h0000, 0, 1);
        clr_on_trans = 1'b0;
        idle(8);
        total++; if (frame_error !== 1'b1) begin bad++; $display("FAIL clr_same_cycle: got %b want 1", frame_error); end
        total++; if (vcnt - base !== 0) begin bad++; $display("FAIL clr_no_commit: got %0d want 0", vcnt - base); end
        error_clear = 1'b1;
        @(posedge clk); #1;
        error_clear = 1'b0;
        idle(2);
        total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL clr_lone: got %b want 0", frame_error); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send_slot(1'b0, 16'hA55A, 0, 32);
        send_slot(1'b1, 16'h1234, 0, 32);
        send_slot(1'b0, 16'h5555, 0, 32);
        send_slot(1'b1, 16'h2222, 0, 31);
        send_slot(1'b0, 16'h5555, 0, 10);
        idle(8);
        total++; if (vcnt - base !== 1) begin bad++; $display("FAIL mid_pre_cnt: got %0d want 1", vcnt - base); end
        total++; if (frame_error !== 1'b1) begin bad++; $display("FAIL mid_pre_err: got %b want 1", frame_error); end
        reset_n = 1'b0;
        #2;
        total++; if (left_sample !== 16'h0000) begin bad++; $display("FAIL mid_async_left: got %h want 0000", left_sample); end
        total++; if (right_sample !== 16'h0000) begin bad++; $display("FAIL mid_async_right: got %h want 0000", right_sample); end
        total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL mid_async_err: got %b want 0", frame_error); end
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b1;
        @(posedge clk); #1;
        send_slot(1'b0, 16'h5555, 10, 22);
        send_slot(1'b1, 16'h6666, 0, 32);
        send_slot(1'b0, 16'h7777, 0, 32);
        idle(8);
        total++; if (vcnt - base !== 1) begin bad++; $display("FAIL mid_partial_drop: got %0d want 1", vcnt - base); end
        send_slot(1'b1, 16'h8888, 0, 32);
        send_slot(1'b0, 16'h0000, 0, 1);
        idle(8);
        total++; if (vcnt - base !== 2) begin bad++; $display("FAIL mid_post_cnt: got %0d want 2", vcnt - base); end
        total++; if (left_sample !== 16'h7777) begin bad++; $display("FAIL mid_post_left: got %h want 7777", left_sample); end
        total++; if (right_sample !== 16'h8888) begin bad++; $display("FAIL mid_post_right: got %h want 8888", right_sample); end
        total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL mid_post_err: got %b want 0", frame_error); end
    endtask

    task automatic test_fast_sclk();
        ph = 3;
        apply_reset();
        send_slot(1'b0, 16'hFFFF, 0, 32);
        send_slot(1'b1, 16'h0000, 0, 32);
        send_slot(1'b0, 16'h0000, 0, 1);
        idle(8);
        total++; if (vcnt - base !== 1) begin bad++; $display("FAIL fast_cnt1: got %0d want 1", vcnt - base); end
        total++; if (left_sample !== 16'hFFFF) begin bad++; $display("FAIL fast_left1: got %h want ffff", left_sample); end
        total++; if (right_sample !== 16'h0000) begin bad++; $display("FAIL fast_right1: got %h want 0000", right_sample); end
        total++; if (vld_cyc - trans_cyc !== SYNC + 2) begin bad++; $display("FAIL fast_latency1: got %0d want %0d", vld_cyc - trans_cyc, SYNC + 2); end
        send_slot(1'b0, 16'h0000, 1, 31);
        send_slot(1'b1, 16'hFFFF, 0, 32);
        send_slot(1'b0, 16'h0000, 0, 1);
        idle(8);
        total++; if (vcnt - base !== 2) begin bad++; $display("FAIL fast_cnt2: got %0d want 2", vcnt - base); end
        total++; if (left_sample !== 16'h0000) begin bad++; $display("FAIL fast_left2: got %h want 0000", left_sample); end
        total++; if (right_sample !== 16'hFFFF) begin bad++; $display("FAIL fast_right2: got %h want ffff", right_sample); end
        total++; if (vld_cyc - trans_cyc !== SYNC + 2) begin bad++; $display("FAIL fast_latency2: got %0d want %0d", vld_cyc - trans_cyc, SYNC + 2); end
        total++; if (consec !== 1'b0) begin bad++; $display("FAIL back_to_back_valid: got %b want 0", consec); end
        ph = 6;
    endtask

`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    task automatic test_left_justified();
        apply_reset();
        send_slot(1'b0, 16'h8001, 0, 32);
        send_slot(1'b1, 16'h7FFE, 0, 32);
        send_slot(1'b0, 16'h0000, 0, 1);
        idle(8);
        total++; if (vcnt - base !== 1) begin bad++; $display("FAIL lj_cnt: got %0d want 1", vcnt - base); end
        total++; if (left_sample !== 16'h8001) begin bad++; $display("FAIL lj_left: got %h want 8001", left_sample); end
        total++; if (right_sample !== 16'h7FFE) begin bad++; $display("FAIL lj_right: got %h want 7ffe", right_sample); end
        total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL lj_err: got %b want 0", frame_error); end
    endtask
`endif

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_standard();
        test_short_slot();
        test_error_clear();
        test_reset_mid();
        test_fast_sclk();
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
        test_left_justified();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
